// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg: pad mode encodings, default sizes and the shared pad-drive decode.
package gpio_pad_pkg;
  localparam logic [1:0] MODE_IN  = 2'b00;
  localparam logic [1:0] MODE_PP  = 2'b01;
  localparam logic [1:0] MODE_OD  = 2'b10;
  localparam logic [1:0] MODE_OFF = 2'b11;
  localparam int DEF_WIDTH    = 4;
  localparam int DEF_FILTER_W = 4;
  // Returns {write_enable, write}. Open-drain only ever pulls low: it releases the bus to send a 1.
  function automatic logic [1:0] pad_drive(input logic [1:0] mode, input logic d);
    return mode == MODE_PP ? {1'b1, d} : mode == MODE_OD ? {~d, 1'b0} : 2'b00;
  endfunction
endpackage

// File: rtl/gpio_pad_filter.sv
// gpio_pad_filter: one pad channel -- 2-flop synchroniser, glitch filter, edge detect.
//   io_clock/io_reset : clock, async active-high reset
//   mode              : channel mode; MODE_OFF freezes the channel
//   pin               : raw asynchronous pad input
//   len               : filter length L (0 = bypass)
//   f                 : filtered value
//   rise/fall         : high in the cycle whose closing edge moves f 0->1 / 1->0
module gpio_pad_filter
  import gpio_pad_pkg::*;
#(
  parameter int FILTER_W = DEF_FILTER_W
) (
  input  logic                io_clock,
  input  logic                io_reset,
  input  logic [1:0]          mode,
  input  logic                pin,
  input  logic [FILTER_W-1:0] len,
  output logic                f,
  output logic                rise,
  output logic                fall
);
  logic hold;
  logic s1_q, s1_d, s_q, s_d, f_q, f_d;
  logic [FILTER_W-1:0] c_q, c_d;
  assign hold = mode == MODE_OFF;
  // c counts edges on which s has disagreed with f; >= lets a lowered L finish a pending change at once.
  always_comb begin
    s1_d = hold ? s1_q : pin;
    s_d  = hold ? s_q : s1_q;
    f_d  = (!hold && s_q != f_q && c_q >= len) ? s_q : f_q;
    c_d  = (hold || s_q == f_q || c_q >= len) ? '0 : c_q + FILTER_W'(1);
  end
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
      f_q  <= 1'b0;
      c_q  <= '0;
    end else begin
      s1_q <= s1_d;
      s_q  <= s_d;
      f_q  <= f_d;
      c_q  <= c_d;
    end
  end
  assign f    = f_q;
  assign rise = ~f_q & f_d;
  assign fall = f_q & ~f_d;
endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: WIDTH-channel GPIO pad controller with registered drive, filtered input and edge IRQs.
//   io_clock/io_reset        : clock, async active-high reset
//   io_mode[2i+1:2i]         : 00 input, 01 push-pull, 10 open-drain, 11 disabled
//   io_dataOut               : output value per channel
//   io_filterLen             : shared glitch-filter length
//   io_irqRiseEn/FallEn      : per-channel edge interrupt enables
//   io_irqClear              : write-1-to-clear pending
//   io_pins_read             : raw pad inputs
//   io_pins_write/WriteEnable: registered pad drive
//   io_dataIn                : filtered inputs
//   io_irqPending/io_irq     : sticky pending bits and their OR
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FILTER_W = DEF_FILTER_W
) (
  input  logic                io_clock,
  input  logic                io_reset,
  input  logic [2*WIDTH-1:0]  io_mode,
  input  logic [WIDTH-1:0]    io_dataOut,
  input  logic [FILTER_W-1:0] io_filterLen,
  input  logic [WIDTH-1:0]    io_irqRiseEn,
  input  logic [WIDTH-1:0]    io_irqFallEn,
  input  logic [WIDTH-1:0]    io_irqClear,
  input  logic [WIDTH-1:0]    io_pins_read,
  output logic [WIDTH-1:0]    io_pins_write,
  output logic [WIDTH-1:0]    io_pins_writeEnable,
  output logic [WIDTH-1:0]    io_dataIn,
  output logic [WIDTH-1:0]    io_irqPending,
  output logic                io_irq
);
  logic [WIDTH-1:0] f, rise, fall;
  logic [WIDTH-1:0] we_q, we_d, wr_q, wr_d, pend_q, pend_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gpio_pad_filter #(.FILTER_W(FILTER_W)) u_filt (
      .io_clock(io_clock),
      .io_reset(io_reset),
      .mode    (io_mode[2*i+:2]),
      .pin     (io_pins_read[i]),
      .len     (io_filterLen),
      .f       (f[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end
  // A new event is OR-ed in after the clear, so set wins over a simultaneous clear.
  always_comb begin
    we_d = '0;
    wr_d = '0;
    for (int i = 0; i < WIDTH; i++) {we_d[i], wr_d[i]} = pad_drive(io_mode[2*i+:2], io_dataOut[i]);
    pend_d = (pend_q & ~io_irqClear) | (rise & io_irqRiseEn) | (fall & io_irqFallEn);
  end
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      we_q   <= '0;
      wr_q   <= '0;
      pend_q <= '0;
    end else begin
      we_q   <= we_d;
      wr_q   <= wr_d;
      pend_q <= pend_d;
    end
  end
  assign io_pins_writeEnable = we_q;
  assign io_pins_write       = wr_q;
  assign io_dataIn           = f;
  assign io_irqPending       = pend_q;
  assign io_irq              = |pend_q;
endmodule
